// File: rtl/div_clk_monitor.sv
// div_clk_monitor: measures period/high time of a divided clock sampled in clk, locks when the ratio equals EXP_DIV.
// Outputs 1 cycle after the detected rise (+2 cycles with DIV_CLK_MONITOR_SYNC_EN defined); no backpressure.
module div_clk_monitor #(
  parameter int CNT_W    = 8,
  parameter int EXP_DIV  = 4,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             err,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] EXP_PER = CNT_W'(EXP_DIV);
  localparam logic [CNT_W-1:0] HI_LO   = CNT_W'(EXP_DIV / 2);
  localparam logic [CNT_W-1:0] HI_HI   = CNT_W'((EXP_DIV + 1) / 2);
  localparam logic [3:0]       LOCK_N  = 4'(LOCK_CNT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MEAS   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             samp_src;
  logic             samp;
  logic             samp_d;
  logic             rise;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] hi_cnt;
  logic [3:0]       match_cnt;
  logic [3:0]       match_inc;
  logic             is_match;
  logic             lock_hit;
  logic             at_max;

`ifdef DIV_CLK_MONITOR_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], clk_in};
    end
  end

  assign samp_src = sync_q[1];
`else
  assign samp_src = clk_in;
`endif

  // Edge flops reset high so a clk_in already high at reset release is not seen as a rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      samp   <= 1'b1;
      samp_d <= 1'b1;
    end else begin
      samp   <= samp_src;
      samp_d <= samp;
    end
  end

  assign rise      = samp & ~samp_d;
  assign at_max    = (per_cnt == CNT_MAX);
  assign is_match  = (per_cnt == EXP_PER) && ((hi_cnt == HI_LO) || (hi_cnt == HI_HI));
  assign match_inc = (match_cnt >= LOCK_N) ? LOCK_N : match_cnt + 4'd1;
  assign lock_hit  = is_match && (match_inc == LOCK_N);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rise) state_nxt = MEAS;
      end
      MEAS, LOCKED: begin
        if (rise) begin
          state_nxt = lock_hit ? LOCKED : MEAS;
        end else if (at_max) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    locked = (state == LOCKED);
  end

  // A rise on the cycle per_cnt sits at its maximum is captured, not timed out.
  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt    <= '0;
      hi_cnt     <= '0;
      match_cnt  <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      err        <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      err        <= 1'b0;
      timeout    <= 1'b0;
      if (state == IDLE) begin
        if (rise) begin
          per_cnt <= CNT_W'(1);
          hi_cnt  <= CNT_W'(1);
        end
      end else if (rise) begin
        period     <= per_cnt;
        high_time  <= hi_cnt;
        meas_valid <= 1'b1;
        per_cnt    <= CNT_W'(1);
        hi_cnt     <= CNT_W'(1);
        if (is_match) begin
          match_cnt <= match_inc;
        end else begin
          match_cnt <= '0;
          err       <= 1'b1;
        end
      end else if (at_max) begin
        timeout   <= 1'b1;
        match_cnt <= '0;
        per_cnt   <= '0;
        hi_cnt    <= '0;
      end else begin
        per_cnt <= per_cnt + CNT_W'(1);
        hi_cnt  <= hi_cnt + {{(CNT_W-1){1'b0}}, samp};
      end
    end
  end

endmodule

// File: doc/div_clk_monitor.md
Name: div_clk_monitor

Overview:
- Checking end of the clock-divider path: samples a divided clock (e.g. clk_4 from the divide-by-4 block) as data in the source clk domain.
- Measures its period and high time in clk cycles, and declares lock once the ratio matches the expected divide factor for a set number of consecutive periods.
- Flags mismatches and a stalled input.
- Used on-chip next to each divider and as a self-checking monitor in divider benches.

Parameters:
- CNT_W, 8: width of the period and high-time counters; max measurable period 2^CNT_W-1.
- EXP_DIV, 4: expected divide ratio (period in clk cycles); legal range 2..2^CNT_W-2.
- LOCK_CNT, 4: consecutive matching periods required to assert locked; legal range 1..15.

Ports:
- clk  input  1  system clock; also the divider's source clock.
- rst  input  1  synchronous reset, active-high.
- clk_in  input  1  divided clock under test, sampled as data on clk rising edge.
- period  output  CNT_W  last measured period, in clk cycles.
- high_time  output  CNT_W  last measured high time, in clk cycles.
- meas_valid  output  1  one-cycle pulse: period/high_time updated.
- locked  output  1  ratio verified LOCK_CNT times in a row.
- err  output  1  one-cycle pulse: a completed period mismatched.
- timeout  output  1  one-cycle pulse: no rising edge within 2^CNT_W-1 cycles.

Behaviour:
- Reset: synchronous, active-high, takes effect on the next clk edge, including mid-measurement. All outputs go to 0, internal counters to 0, and state to IDLE.
- Edge detect: samp is clk_in registered, samp_d is samp delayed by one cycle; rise = samp & ~samp_d.
- States:
  - IDLE: waits for rise. On rise, per_cnt=1, hi_cnt=1, go to MEAS. The first edge never produces a measurement.
  - MEAS / LOCKED, each cycle without rise: per_cnt+1; hi_cnt+1 if samp=1.
  - MEAS / LOCKED, on rise: capture period=per_cnt and high_time=hi_cnt, pulse meas_valid; then restart per_cnt=1, hi_cnt=1.
- Latency: period, high_time and meas_valid are registered and appear one cycle after the rise is detected. For a steady divide-by-4 input this gives period=4, high_time=2.
- Match rule:
  - Even EXP_DIV: period==EXP_DIV and high_time==EXP_DIV/2.
  - Odd EXP_DIV: high_time equal to floor(EXP_DIV/2) or ceil(EXP_DIV/2) is accepted.
- On a match: match_cnt+1, saturating at LOCK_CNT. locked=1 in the same cycle that meas_valid reports the LOCK_CNT-th consecutive match; state becomes LOCKED.
- On a mismatch: err pulse coincident with meas_valid; match_cnt=0; locked=0; state MEAS. The new period starts counting immediately.
- Timeout: if per_cnt reaches 2^CNT_W-1 without rise, then timeout pulses, locked=0, match_cnt=0 and state goes to IDLE. No meas_valid is issued. per_cnt never wraps. A constant-high or constant-low clk_in therefore times out.
- Rise on the same cycle per_cnt hits 2^CNT_W-1: the rise wins. The measurement is captured as 2^CNT_W-1 and no timeout is raised.
- Outputs period and high_time hold their last values until the next capture or reset.

Optional Feature:
- Macro: DIV_CLK_MONITOR_SYNC_EN.
- Defined: clk_in passes through a 2-flop synchronizer before samp, so an asynchronous or foreign-domain clock can be monitored. Adds 2 cycles of edge-to-output latency; measured values are unchanged for inputs synchronous to clk.
- Undefined: single sampling flop only; clk_in must be synchronous to clk.

Test Plan:
- Reset 5 cycles, then steady divide-by-4 stream (2 high/2 low), EXP_DIV=4, LOCK_CNT=4 -> first meas_valid one cycle after the 2nd rise with period=4, high_time=2; locked=1 with the 4th meas_valid; err and timeout stay 0.
- Locked, then insert one 3-cycle period (2 high/1 low) -> err and meas_valid together with period=3; locked drops the same cycle; locked returns after 4 further good periods.
- Locked, then hold clk_in low -> timeout pulses exactly 255 cycles after the last rise (CNT_W=8); locked=0; state IDLE; the next rise produces no meas_valid.
- EXP_DIV=3 with alternating duty 1/2 and 2/1 -> every period reports 3; no err; locked after LOCK_CNT periods.
- Assert rst for 1 cycle mid-period while locked -> all outputs 0 next cycle; lock is re-acquired only after 1 + LOCK_CNT rises.
- With DIV_CLK_MONITOR_SYNC_EN defined, repeat the first scenario -> identical values; every meas_valid is 2 cycles later.
